// File: rtl/dm_store_buffer_if.sv
// rtl/dm_store_buffer_if.sv - store buffer bus bundle: store port, load lookup, DM drain port
interface dm_store_buffer_if #(
    parameter int AW = 2
);
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        drain_en;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic        empty;
    logic [AW:0] count;

    // CPU side: issues stores and load lookups, grants the DM write port
    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_addr, drain_en,
        input  st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_wd, dm_pc, empty, count
    );

    // Buffer side
    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_addr, drain_en,
        output st_ready, ld_hit, ld_data, dm_we, dm_addr, dm_wd, dm_pc, empty, count
    );
endinterface

// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - word-store FIFO in front of the DM with youngest-match load forwarding
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    dm_store_buffer_if.slave bus
);
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] head_d;
    logic [AW-1:0] tail_q;
    logic [AW-1:0] tail_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    logic          full;
    logic          is_empty;
    logic          push;
    logic          pop;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [AW-1:0] fwd_idx;
    logic [1:0]    ld_addr_unused;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign is_empty = (count_q == '0);
    // No push-through when full, even if the head drains this cycle
    assign push     = bus.st_valid && !full;
    // Gated by reset so a discarded store never reaches the DM
    assign pop      = !is_empty && bus.drain_en && !reset;

    assign bus.st_ready = !full;
    assign bus.empty    = is_empty;
    assign bus.count    = count_q;
    assign bus.dm_we    = pop;
    assign bus.dm_addr  = is_empty ? 32'h0 : addr_q[head_q];
    assign bus.dm_wd    = is_empty ? 32'h0 : data_q[head_q];
    assign bus.dm_pc    = is_empty ? 32'h0 : pc_q[head_q];
    assign bus.ld_hit   = fwd_hit;
    assign bus.ld_data  = fwd_data;

    // Byte offset of the load does not matter for word matching
    assign ld_addr_unused = bus.ld_addr[1:0];

    // Next-state pointers and occupancy from this cycle's push/pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Forwarding: walk from oldest to youngest so the last match (youngest) wins;
    // the head still counts while it drains, a same-cycle push does not
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'h0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + AW'(i);
            if (((AW+1)'(i) < count_q) && (addr_q[fwd_idx][31:2] == bus.ld_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    // Entry storage; contents need no reset since count gates every use
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= bus.st_addr;
            data_q[tail_q] <= bus.st_data;
            pc_q[tail_q]   <= bus.st_pc;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - self-checking bench for dm_store_buffer
module tb_dm_store_buffer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    dm_store_buffer_if #(.AW(2)) bus ();

    dm_store_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [31:0] sp;
        logic [31:0] la;
        logic        de;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [31:0] e_pc;
        logic        e_hit;
        logic [31:0] e_ld;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    vec_t vecs [18];
    ent_t model_q [$];

    function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                input logic [31:0] sp, input logic [31:0] la, input logic de,
                                input logic rdy, input logic [2:0] cnt, input logic we,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                                input logic hit, input logic [31:0] ld);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.sp = sp; v.la = la; v.de = de;
        v.e_rdy = rdy; v.e_cnt = cnt; v.e_we = we; v.e_addr = addr; v.e_wd = wd;
        v.e_pc = pc; v.e_hit = hit; v.e_ld = ld;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [31:0] sp, input logic [31:0] la, input logic de);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.st_pc    = sp;
        bus.ld_addr  = la;
        bus.drain_en = de;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = mk(0, 32'h0,  32'h0,        32'h0,    32'h10, 0, 1, 0, 0, 32'h0,  32'h0,        32'h0,    0, 32'h0);
        vecs[1]  = mk(1, 32'h10, 32'hAAAA0001, 32'h3000, 32'h10, 1, 1, 0, 0, 32'h0,  32'h0,        32'h0,    0, 32'h0);
        vecs[2]  = mk(0, 32'h0,  32'h0,        32'h0,    32'h10, 1, 1, 1, 1, 32'h10, 32'hAAAA0001, 32'h3000, 1, 32'hAAAA0001);
        vecs[3]  = mk(0, 32'h0,  32'h0,        32'h0,    32'h10, 1, 1, 0, 0, 32'h0,  32'h0,        32'h0,    0, 32'h0);
        vecs[4]  = mk(1, 32'h0,  32'hD0D00000, 32'h3100, 32'h0,  0, 1, 0, 0, 32'h0,  32'h0,        32'h0,    0, 32'h0);
        vecs[5]  = mk(1, 32'h4,  32'hD0D00001, 32'h3104, 32'h0,  0, 1, 1, 0, 32'h0,  32'hD0D00000, 32'h3100, 1, 32'hD0D00000);
        vecs[6]  = mk(1, 32'h8,  32'hD0D00002, 32'h3108, 32'h4,  0, 1, 2, 0, 32'h0,  32'hD0D00000, 32'h3100, 1, 32'hD0D00001);
        vecs[7]  = mk(1, 32'hC,  32'hD0D00003, 32'h310C, 32'h8,  0, 1, 3, 0, 32'h0,  32'hD0D00000, 32'h3100, 1, 32'hD0D00002);
        vecs[8]  = mk(1, 32'h20, 32'hD0D00004, 32'h3110, 32'hC,  0, 0, 4, 0, 32'h0,  32'hD0D00000, 32'h3100, 1, 32'hD0D00003);
        vecs[9]  = mk(0, 32'h0,  32'h0,        32'h0,    32'h20, 1, 0, 4, 1, 32'h0,  32'hD0D00000, 32'h3100, 0, 32'h0);
        vecs[10] = mk(0, 32'h0,  32'h0,        32'h0,    32'h0,  1, 1, 3, 1, 32'h4,  32'hD0D00001, 32'h3104, 0, 32'h0);
        vecs[11] = mk(0, 32'h0,  32'h0,        32'h0,    32'h8,  1, 1, 2, 1, 32'h8,  32'hD0D00002, 32'h3108, 1, 32'hD0D00002);
        vecs[12] = mk(0, 32'h0,  32'h0,        32'h0,    32'h20, 1, 1, 1, 1, 32'hC,  32'hD0D00003, 32'h310C, 0, 32'h0);
        vecs[13] = mk(0, 32'h0,  32'h0,        32'h0,    32'h20, 1, 1, 0, 0, 32'h0,  32'h0,        32'h0,    0, 32'h0);
        vecs[14] = mk(1, 32'h40, 32'h11111111, 32'h4000, 32'h40, 0, 1, 0, 0, 32'h0,  32'h0,        32'h0,    0, 32'h0);
        vecs[15] = mk(1, 32'h40, 32'h22222222, 32'h4004, 32'h42, 0, 1, 1, 0, 32'h40, 32'h11111111, 32'h4000, 1, 32'h11111111);
        vecs[16] = mk(0, 32'h0,  32'h0,        32'h0,    32'h42, 0, 1, 2, 0, 32'h40, 32'h11111111, 32'h4000, 1, 32'h22222222);
        vecs[17] = mk(0, 32'h0,  32'h0,        32'h0,    32'h44, 0, 1, 2, 0, 32'h40, 32'h11111111, 32'h4000, 0, 32'h0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        // Directed vectors: basic drain, fill/drop/ordered drain, forwarding
        for (int r = 0; r < 18; r++) begin
            drive(vecs[r].sv, vecs[r].sa, vecs[r].sd, vecs[r].sp, vecs[r].la, vecs[r].de);
            @(negedge clk);
            chk($sformatf("v%0d st_ready", r), 32'(bus.st_ready), 32'(vecs[r].e_rdy));
            chk($sformatf("v%0d count", r),    32'(bus.count),    32'(vecs[r].e_cnt));
            chk($sformatf("v%0d empty", r),    32'(bus.empty),    32'(vecs[r].e_cnt == 3'd0));
            chk($sformatf("v%0d dm_we", r),    32'(bus.dm_we),    32'(vecs[r].e_we));
            chk($sformatf("v%0d dm_addr", r),  bus.dm_addr,       vecs[r].e_addr);
            chk($sformatf("v%0d dm_wd", r),    bus.dm_wd,         vecs[r].e_wd);
            chk($sformatf("v%0d dm_pc", r),    bus.dm_pc,         vecs[r].e_pc);
            chk($sformatf("v%0d ld_hit", r),   32'(bus.ld_hit),   32'(vecs[r].e_hit));
            chk($sformatf("v%0d ld_data", r),  bus.ld_data,       vecs[r].e_ld);
            tick();
        end

        // Full buffer: pop with rejected push, then push+pop across the wrap
        drive(1, 32'h50, 32'h50505050, 32'h4008, 32'h0, 0);
        tick();
        drive(1, 32'h54, 32'h54545454, 32'h400C, 32'h0, 0);
        tick();
        drive(1, 32'h58, 32'h58585858, 32'h4010, 32'h58, 1);
        @(negedge clk);
        chk("full count", 32'(bus.count), 32'd4);
        chk("full st_ready", 32'(bus.st_ready), 32'd0);
        chk("full dm_we", 32'(bus.dm_we), 32'd1);
        chk("full dm_wd", bus.dm_wd, 32'h11111111);
        chk("full dropped not visible", 32'(bus.ld_hit), 32'd0);
        tick();
        drive(1, 32'h5C, 32'h5C5C5C5C, 32'h4014, 32'h40, 1);
        @(negedge clk);
        chk("after rej count", 32'(bus.count), 32'd3);
        chk("after rej st_ready", 32'(bus.st_ready), 32'd1);
        chk("after rej dm_wd", bus.dm_wd, 32'h22222222);
        chk("head drain fwd hit", 32'(bus.ld_hit), 32'd1);
        chk("head drain fwd data", bus.ld_data, 32'h22222222);
        tick();
        drive(0, 0, 0, 0, 32'h5C, 1);
        @(negedge clk);
        chk("pushpop count", 32'(bus.count), 32'd3);
        chk("wrap order 0", bus.dm_addr, 32'h50);
        chk("wrap fwd data", bus.ld_data, 32'h5C5C5C5C);
        tick();
        @(negedge clk);
        chk("wrap order 1", bus.dm_addr, 32'h54);
        tick();
        @(negedge clk);
        chk("wrap order 2", bus.dm_addr, 32'h5C);
        chk("wrap order 2 pc", bus.dm_pc, 32'h4014);
        chk("wrap order 2 count", 32'(bus.count), 32'd1);
        tick();
        @(negedge clk);
        chk("wrap drained empty", 32'(bus.empty), 32'd1);
        chk("wrap drained dm_we", 32'(bus.dm_we), 32'd0);
        tick();

        // Reset with pending stores
        drive(1, 32'h60, 32'h60606060, 32'h4100, 32'h0, 0);
        tick();
        drive(1, 32'h64, 32'h64646464, 32'h4104, 32'h0, 0);
        tick();
        drive(1, 32'h68, 32'h68686868, 32'h4108, 32'h0, 0);
        tick();
        drive(0, 0, 0, 0, 32'h60, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset cycle dm_we", 32'(bus.dm_we), 32'd0);
        chk("reset cycle count", 32'(bus.count), 32'd3);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h60, 0);
        @(negedge clk);
        chk("post reset count", 32'(bus.count), 32'd0);
        chk("post reset empty", 32'(bus.empty), 32'd1);
        for (int k = 0; k < 3; k++) begin
            bus.ld_addr = 32'h60 + 32'(4 * k);
            #1;
            chk($sformatf("post reset hit %0d", k), 32'(bus.ld_hit), 32'd0);
        end
        tick();

        // Streaming at one store per cycle
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                drive(1, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 32'h5000 + 32'(4 * i), 32'h0, 1);
            end else begin
                drive(0, 0, 0, 0, 32'h0, 1);
            end
            @(negedge clk);
            chk($sformatf("stream%0d st_ready", i), 32'(bus.st_ready), 32'd1);
            chk($sformatf("stream%0d count", i), 32'(bus.count), (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) begin
                chk($sformatf("stream%0d dm_we", i), 32'(bus.dm_we), 32'd1);
                chk($sformatf("stream%0d dm_addr", i), bus.dm_addr, 32'h100 + 32'(4 * (i - 1)));
                chk($sformatf("stream%0d dm_pc", i), bus.dm_pc, 32'h5000 + 32'(4 * (i - 1)));
                chk($sformatf("stream%0d dm_wd", i), bus.dm_wd, 32'hC0DE0000 + 32'(i - 1));
            end
            tick();
        end
        drive(0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        chk("stream end empty", 32'(bus.empty), 32'd1);
        tick();

        // Randomized traffic against a queue model
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic        r_rst;
            logic        r_sv;
            logic        r_de;
            logic [31:0] r_sa;
            logic [31:0] r_la;
            logic [31:0] r_sd;
            logic [31:0] r_sp;
            logic        x_we;
            logic        x_hit;
            logic [31:0] x_ld;
            logic        acc;
            ent_t        e;

            r_rst = ($urandom_range(0, 39) == 0);
            r_sv  = ($urandom_range(0, 2) != 0);
            r_de  = ($urandom_range(0, 2) == 0);
            r_sa  = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            r_la  = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            r_sd  = $urandom;
            r_sp  = 32'h6000 + 32'(c * 4);
            drive(r_sv, r_sa, r_sd, r_sp, r_la, r_de);
            reset = r_rst;

            x_we  = (model_q.size() > 0) && r_de && !r_rst;
            x_hit = 1'b0;
            x_ld  = 32'h0;
            for (int j = model_q.size() - 1; j >= 0; j--) begin
                if (!x_hit && (model_q[j].addr >> 2) == (r_la >> 2)) begin
                    x_hit = 1'b1;
                    x_ld  = model_q[j].data;
                end
            end

            @(negedge clk);
            chk($sformatf("rnd%0d count", c), 32'(bus.count), 32'(model_q.size()));
            chk($sformatf("rnd%0d st_ready", c), 32'(bus.st_ready), 32'(model_q.size() < 4));
            chk($sformatf("rnd%0d empty", c), 32'(bus.empty), 32'(model_q.size() == 0));
            chk($sformatf("rnd%0d dm_we", c), 32'(bus.dm_we), 32'(x_we));
            chk($sformatf("rnd%0d dm_addr", c), bus.dm_addr, (model_q.size() > 0) ? model_q[0].addr : 32'h0);
            chk($sformatf("rnd%0d dm_wd", c), bus.dm_wd, (model_q.size() > 0) ? model_q[0].data : 32'h0);
            chk($sformatf("rnd%0d dm_pc", c), bus.dm_pc, (model_q.size() > 0) ? model_q[0].pc : 32'h0);
            chk($sformatf("rnd%0d ld_hit", c), 32'(bus.ld_hit), 32'(x_hit));
            chk($sformatf("rnd%0d ld_data", c), bus.ld_data, x_ld);

            acc = r_sv && (model_q.size() < 4);
            if (r_rst) begin
                model_q.delete();
            end else begin
                if (x_we) begin
                    void'(model_q.pop_front());
                end
                if (acc) begin
                    e.addr = r_sa;
                    e.data = r_sd;
                    e.pc   = r_sp;
                    model_q.push_back(e);
                end
            end
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Word-store FIFO that sits directly upstream of the data memory (DM) in the single-cycle datapath. It accepts word stores from the execute/memory logic, holds up to DEPTH of them, and drains one per cycle into the DM write port. Loads look up the buffer combinationally and receive the youngest matching pending store, so software never observes stale DM contents. Each store's PC is carried to the DM so the DM's write trace stays correct.

## Interface
Parameters:
- DEPTH, 4: number of entries; must be a power of two, at least 2.
- AW, 2: log2(DEPTH), used for the pointers.

Ports (name, direction, width, meaning):
- clk, in, 1: clock. All state updates on the rising edge.
- reset, in, 1: synchronous, active-high. Empties the buffer.
- st_valid, in, 1: a store request is present this cycle.
- st_ready, out, 1: buffer can accept; equals !full.
- st_addr, in, 32: store byte address. Bits [1:0] are carried but ignored for matching.
- st_data, in, 32: store word.
- st_pc, in, 32: PC of the store instruction.
- ld_addr, in, 32: load byte address for the forwarding lookup.
- ld_hit, out, 1: a pending entry matches ld_addr[31:2].
- ld_data, out, 32: data of the youngest matching entry; 0 when ld_hit=0.
- drain_en, in, 1: DM write port may be used this cycle.
- dm_we, out, 1: DM write enable.
- dm_addr, out, 32: address of the head entry.
- dm_wd, out, 32: data of the head entry.
- dm_pc, out, 32: PC of the head entry.
- empty, out, 1: no pending entries; the CPU uses it as the drain-complete condition before halt.
- count, out, AW+1: number of pending entries, 0..DEPTH.

## Operation
- Storage: a circular array of {addr, data, pc} entries, plus head pointer, tail pointer and count. Pointers are AW bits wide and wrap from DEPTH-1 to 0.
- Push: when st_valid && st_ready, write the entry at the tail, then tail+1.
- Pop: when dm_we, then head+1. dm_we = !empty && drain_en. dm_addr, dm_wd and dm_pc are driven combinationally from the head entry. When empty, they are driven to 0.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full (count==DEPTH): st_ready=0. A push attempted while full is dropped; the upstream logic must stall. There is no push-through when full, even if a pop happens in the same cycle.
- Empty with push in the same cycle: the new entry is not drained that cycle (dm_we=0). It is drainable from the next cycle.
- Forwarding: ld_addr[31:2] is compared against addr[31:2] of every valid entry (the entries between head and tail, count long).
  - The youngest match (closest to the tail) wins.
  - The head entry still participates in the cycle it is being drained, because the DM write commits only at that edge.
  - A store being pushed in the same cycle is not visible to the lookup.
- Reset: head=0, tail=0, count=0. Entry contents are don't-care. A reset asserted mid-operation discards all pending stores; no DM write occurs in the reset cycle because dm_we is gated by !reset.

## Timing
- Reset values: st_ready=1, empty=1, count=0, dm_we=0, dm_addr=0, dm_wd=0, dm_pc=0, ld_hit=0, ld_data=0.
- Store accepted at edge N: it appears on dm_* and is eligible for dm_we in the cycle after edge N. Minimum store-to-DM-commit latency is 2 edges.
- With drain_en held high, throughput is one store per cycle in and one per cycle out.
- The forwarding path and dm_* are purely combinational from registered state plus ld_addr/drain_en; there is no registered output latency.
- Stores drain strictly in FIFO order. Two stores to the same word commit in program order.

## Test plan
- Reset, then push addr 0x10 / data 0xAAAA0001 / pc 0x3000 with drain_en=1. Required: next cycle dm_we=1, dm_addr=0x10, dm_wd=0xAAAA0001, dm_pc=0x3000; the following cycle empty=1.
- drain_en=0, push 4 stores (addr 0x0, 0x4, 0x8, 0xC). Required: count=4, st_ready=0. A 5th push (addr 0x20) is dropped. Then raise drain_en: writes come out in order 0x0, 0x4, 0x8, 0xC; 0x20 never appears.
- drain_en=0, push 0x40 / 0x11111111, then 0x40 / 0x22222222. Required: ld_addr=0x42 gives ld_hit=1, ld_data=0x22222222. ld_addr=0x44 gives ld_hit=0, ld_data=0.
- Full buffer, simultaneous pop and push attempt. Required: push rejected, count=3 afterwards. In the next cycle, push plus pop together leave count=3 and the pointers wrap correctly across index DEPTH-1 to 0.
- 3 entries pending, assert reset for one cycle with drain_en=1. Required: dm_we=0 in that cycle; afterwards count=0, empty=1, ld_hit=0 for all earlier addresses.
- Continuous streaming with drain_en=1 for 20 cycles, one push per cycle at 0x100+4i. Required: count stays at most 1, st_ready never drops, and DM writes appear one cycle after each push with matching PC.
